// File: rtl/udp_rx_pkg.sv
// Shared types and helpers for the UDP port receivers.
//   rx_state_t     : parser state (sequence field / payload)
//   rx_err_t       : per-packet error pulses
//   word_width     : bytes -> bits
//   lane_cnt_width : width of a byte-lane counter covering both fields
package udp_rx_pkg;

    typedef enum logic {
        S_SEQ     = 1'b0,
        S_PAYLOAD = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic seq_num;
        logic short_pkt;
        logic frag;
    } rx_err_t;

    function automatic int word_width(input int bytes);
        return 8 * bytes;
    endfunction

    // Counter must index lanes 0..max(seq_bytes, word_bytes)-1.
    function automatic int lane_cnt_width(input int seq_bytes, input int word_bytes);
        int lanes;
        lanes = (seq_bytes > word_bytes) ? seq_bytes : word_bytes;
        return (lanes <= 2) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/udp_unpack_word_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst   : clock, async active-high reset
//   push       : write request (ignored when full unless a pop happens the same cycle)
//   push_data  : write data
//   pop        : read request (ignored when empty)
//   pop_data   : head entry, valid while !empty
//   full/empty : occupancy flags
//   level      : number of stored entries
module udp_unpack_word_fifo #(
    parameter int P_WIDTH = 33,
    parameter int P_DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [P_WIDTH-1:0]         push_data,
    input  logic                       pop,
    output logic [P_WIDTH-1:0]         pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(P_DEPTH):0]   level
);
    localparam int ADDR_W = $clog2(P_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full     = (level == LVL_W'(P_DEPTH));
    assign empty    = (level == '0);
    assign pop_ok   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok  = push & (~full | pop_ok);
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; entries are only observed behind empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/udp_port_word_unpacker.sv
// Strips a big-endian sequence number from each UDP packet, checks it against
// the running expectation, and packs payload bytes into words (with even
// parity) queued in an FWFT FIFO.
//   i_sys_clk / i_sys_arst          : clock, async active-high reset
//   i_port_byte / _vld / _last_byte : FWFT byte stream from the packet router
//   o_port_byte_rd                  : consume strobe back to the router
//   i_word_rd                       : pop the head word
//   o_word / o_word_parity / _vld   : FIFO head word, its parity, not-empty
//   o_seq_num_error / o_short_pkt_error / o_frag_error : 1-cycle error pulses
//   o_fifo_overflow                 : sticky, word dropped (no-backpressure build)
//   o_fifo_underflow                : 1-cycle pulse, pop requested while empty
module udp_port_word_unpacker
    import udp_rx_pkg::*;
#(
    parameter int P_WORD_BYTES      = 4,
    parameter int P_SEQ_NUM_BYTES   = 4,
    parameter int P_FIFO_WORD_DEPTH = 512,
    parameter int P_BIG_ENDIAN      = 1,
    parameter int P_BACKPRESSURE    = 1
) (
    input  logic                        i_sys_clk,
    input  logic                        i_sys_arst,
    input  logic [7:0]                  i_port_byte,
    input  logic                        i_port_byte_vld,
    input  logic                        i_port_last_byte,
    output logic                        o_port_byte_rd,
    input  logic                        i_word_rd,
    output logic [8*P_WORD_BYTES-1:0]   o_word,
    output logic                        o_word_parity,
    output logic                        o_word_vld,
    output logic                        o_seq_num_error,
    output logic                        o_short_pkt_error,
    output logic                        o_frag_error,
    output logic                        o_fifo_overflow,
    output logic                        o_fifo_underflow
);
    localparam int WORD_W = word_width(P_WORD_BYTES);
    localparam int SEQ_W  = word_width(P_SEQ_NUM_BYTES);
    localparam int CNT_W  = lane_cnt_width(P_SEQ_NUM_BYTES, P_WORD_BYTES);
    localparam int LVL_W  = $clog2(P_FIFO_WORD_DEPTH) + 1;
    localparam logic [CNT_W-1:0] SEQ_LAST  = CNT_W'(P_SEQ_NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(P_WORD_BYTES - 1);

    rx_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [SEQ_W-1:0]   seq_sr;
    logic [SEQ_W-1:0]   exp_seq;
    logic               exp_vld;
    logic [WORD_W-1:0]  word_q;
    logic               wr_en_q;
    logic [WORD_W-1:0]  wr_word_q;
    rx_err_t            err_q;

    logic [SEQ_W-1:0]   rx_seq;
    logic [WORD_W-1:0]  word_next;
    logic               stall;
    logic               take;

    logic [WORD_W:0]    fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;

    assign rx_seq    = (seq_sr << 8) | SEQ_W'(i_port_byte);
    assign word_next = (P_BIG_ENDIAN != 0) ? ((word_q << 8) | WORD_W'(i_port_byte))
                                           : ((word_q >> 8) | (WORD_W'(i_port_byte) << (WORD_W - 8)));

    // The word being committed is not yet in the level, so stall one entry early
    // when it would take the last slot.
    assign stall = (P_BACKPRESSURE != 0) && (state == S_PAYLOAD) &&
                   (fifo_full || (wr_en_q && fifo_level == LVL_W'(P_FIFO_WORD_DEPTH - 1)));
    assign o_port_byte_rd = ~i_sys_arst & ~stall;
    assign take           = i_port_byte_vld & o_port_byte_rd;

    always_ff @(posedge i_sys_clk or posedge i_sys_arst) begin
        if (i_sys_arst) begin
            state     <= S_SEQ;
            cnt       <= '0;
            seq_sr    <= '0;
            exp_seq   <= '0;
            exp_vld   <= 1'b0;
            word_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_word_q <= '0;
            err_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= '0;
            if (take) begin
                case (state)
                    S_SEQ: begin
                        seq_sr <= rx_seq;
                        if (cnt == SEQ_LAST) begin
                            // First packet after reset only seeds the expectation.
                            cnt           <= '0;
                            exp_seq       <= rx_seq + SEQ_W'(1);
                            exp_vld       <= 1'b1;
                            err_q.seq_num <= exp_vld && (rx_seq != exp_seq);
                            state         <= i_port_last_byte ? S_SEQ : S_PAYLOAD;
                        end else if (i_port_last_byte) begin
                            cnt             <= '0;
                            err_q.short_pkt <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_PAYLOAD: begin
                        word_q <= word_next;
                        if (cnt == WORD_LAST) begin
                            cnt       <= '0;
                            wr_en_q   <= 1'b1;
                            wr_word_q <= word_next;
                        end else if (i_port_last_byte) begin
                            cnt        <= '0;
                            err_q.frag <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (i_port_last_byte) state <= S_SEQ;
                    end
                    default: state <= S_SEQ;
                endcase
            end
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_arst) begin
        if (i_sys_arst) begin
            o_fifo_overflow  <= 1'b0;
            o_fifo_underflow <= 1'b0;
        end else begin
            o_fifo_underflow <= i_word_rd & fifo_empty;
            // A full FIFO implies non-empty, so a read request frees a slot.
            if ((P_BACKPRESSURE == 0) && wr_en_q && fifo_full && !i_word_rd)
                o_fifo_overflow <= 1'b1;
        end
    end

    udp_unpack_word_fifo #(
        .P_WIDTH (WORD_W + 1),
        .P_DEPTH (P_FIFO_WORD_DEPTH)
    ) u_fifo (
        .clk       (i_sys_clk),
        .rst       (i_sys_arst),
        .push      (wr_en_q),
        .push_data ({^wr_word_q, wr_word_q}),
        .pop       (i_word_rd),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign o_word_vld        = ~fifo_empty;
    assign o_word            = fifo_empty ? '0   : fifo_dout[WORD_W-1:0];
    assign o_word_parity     = fifo_empty ? 1'b0 : fifo_dout[WORD_W];
    assign o_seq_num_error   = err_q.seq_num;
    assign o_short_pkt_error = err_q.short_pkt;
    assign o_frag_error      = err_q.frag;

endmodule
